// File: rtl/mem_stage.sv
// mem_stage: memory stage of an RV32I pipeline.
// Accepts one EX result per cycle. ALU results are registered straight
// through to writeback. Loads and stores are issued over a req/ack
// data-memory handshake while the upstream pipeline is stalled.
// Misaligned accesses and undefined funct3 codes never reach memory;
// they retire after one cycle with writeback disabled and a misalign pulse.
module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              mem_rd_i,
  input  logic              mem_we_i,
  input  logic [2:0]        mem_func3_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_sdata_i,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              valid_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              misalign_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]        state;

  // Fields of the in-flight access needed when the ack arrives
  logic [4:0]        lat_wd;
  logic              lat_wreg;
  logic              lat_load;
  logic [2:0]        lat_f3;
  logic [1:0]        lat_a;

  // Decode of the incoming instruction
  logic              is_mem;
  logic              f3_ok;
  logic              misal;
  logic [1:0]        a;
  logic [3:0]        req_be;
  logic [DATA_W-1:0] req_wdata;

  // Load data path
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_data;

  assign a      = mem_addr_i[1:0];
  assign is_mem = mem_rd_i | mem_we_i;

  // Classify the access and build byte enables / lane-replicated store data
  always_comb begin
    f3_ok     = 1'b0;
    misal     = 1'b0;
    req_be    = 4'b1111;
    req_wdata = mem_sdata_i;
    case (mem_func3_i)
      3'b000: begin
        f3_ok = 1'b1;
        if (!mem_rd_i) begin
          req_be    = 4'b0001 << a;
          req_wdata = {4{mem_sdata_i[7:0]}};
        end
      end
      3'b001: begin
        f3_ok = 1'b1;
        misal = a[0];
        if (!mem_rd_i) begin
          req_be    = 4'b0011 << a;
          req_wdata = {2{mem_sdata_i[15:0]}};
        end
      end
      3'b010: begin
        f3_ok = 1'b1;
        misal = (a != 2'b00);
      end
      3'b100, 3'b101: begin
        f3_ok = mem_rd_i;
        misal = mem_func3_i[0] & a[0];
      end
      default: begin
        f3_ok = 1'b0;
      end
    endcase
  end

  // Pick the addressed byte/half out of the returned word and extend it
  always_comb begin
    shifted = mem_rdata_i >> {lat_a, 3'b000};
    case (lat_f3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Stage state machine and all registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      stall_o     <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= 4'b0000;
      mem_wdata_o <= '0;
      valid_o     <= 1'b0;
      wd_o        <= 5'd0;
      wreg_o      <= 1'b0;
      wdata_o     <= '0;
      misalign_o  <= 1'b0;
      lat_wd      <= 5'd0;
      lat_wreg    <= 1'b0;
      lat_load    <= 1'b0;
      lat_f3      <= 3'd0;
      lat_a       <= 2'd0;
    end else begin
      valid_o    <= 1'b0;
      misalign_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            if (!is_mem) begin
              valid_o <= 1'b1;
              wd_o    <= wd_i;
              wreg_o  <= wreg_i;
              wdata_o <= wdata_i;
            end else if (!f3_ok || misal) begin
              valid_o    <= 1'b1;
              wd_o       <= wd_i;
              wreg_o     <= 1'b0;
              misalign_o <= 1'b1;
            end else begin
              state       <= BUSY;
              stall_o     <= 1'b1;
              mem_req_o   <= 1'b1;
              mem_we_o    <= ~mem_rd_i;
              mem_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
              mem_be_o    <= req_be;
              mem_wdata_o <= req_wdata;
              lat_wd      <= wd_i;
              lat_wreg    <= wreg_i;
              lat_load    <= mem_rd_i;
              lat_f3      <= mem_func3_i;
              lat_a       <= a;
            end
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            state     <= IDLE;
            stall_o   <= 1'b0;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            valid_o   <= 1'b1;
            wd_o      <= lat_wd;
            if (lat_load) begin
              wreg_o  <= lat_wreg;
              wdata_o <= load_data;
            end else begin
              wreg_o  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a
// reference model computed from the RV32I load/store rules.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic        mem_rd_i;
  logic        mem_we_i;
  logic [2:0]  mem_func3_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_sdata_i;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        valid_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        misalign_o;

  int vectors = 0;
  int miscompares = 0;

  // Observations gathered by issue_op
  logic        obs_req, obs_we, obs_valid, obs_wreg, obs_misalign;
  logic        obs_stable, obs_early_valid, obs_stall_after, obs_req_after;
  logic [31:0] obs_addr, obs_mwdata, obs_wdata;
  logic [3:0]  obs_be;
  logic [4:0]  obs_wd;
  int          obs_stall_cnt, obs_lat;

  typedef struct {
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] wdata;
    bit          wreg;
    bit          misalign;
    bit          chk_wdata;
    bit          chk_wd;
    int          lat;
  } exp_t;

  mem_stage dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .mem_rd_i(mem_rd_i), .mem_we_i(mem_we_i),
    .mem_func3_i(mem_func3_i), .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
    .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .valid_o(valid_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .misalign_o(misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the stage must produce for one instruction
  function automatic exp_t model(input bit rd, input bit we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [31:0] rdata, input bit wreg,
                                 input logic [31:0] alu, input int ack_wait);
    exp_t e;
    int size;
    int ofs;
    bit legal;
    longint v;
    longint span;
    e = '{default: 0};
    if (!(rd || we)) begin
      e.wdata = alu; e.wreg = wreg; e.lat = 1; e.chk_wdata = 1; e.chk_wd = 1;
      return e;
    end
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    legal = (size != 0) && (rd ? !(size == 4 && f3[2]) : !f3[2]);
    ofs = int'(addr % 4);
    if (!legal || (ofs % size) != 0) begin
      e.misalign = 1; e.wreg = 0; e.lat = 1;
      return e;
    end
    e.req = 1;
    e.we = !rd;
    e.addr = addr - ofs;
    e.lat = ack_wait + 2;
    if (rd) begin
      e.be = 4'b1111;
      span = longint'(1) << (8 * size);
      v = (longint'(rdata) >> (8 * ofs)) % span;
      if (!f3[2] && size < 4 && v >= span / 2) v = v - span + (longint'(1) << 32);
      e.wdata = v[31:0];
      e.wreg = wreg;
      e.chk_wdata = 1;
      e.chk_wd = 1;
    end else begin
      e.be = 4'(((1 << size) - 1) << ofs);
      for (int k = 0; k < 4; k++) e.mwdata[8*k +: 8] = sdata[8*(k % size) +: 8];
      e.wreg = 0;
    end
    return e;
  endfunction

  // Drive one instruction, play memory with the given wait count, gather results
  task automatic issue_op(input bit rd, input bit we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input logic [4:0] wd,
                          input bit wreg, input logic [31:0] alu, input int ack_wait);
    valid_i = 1'b1; mem_rd_i = rd; mem_we_i = we; mem_func3_i = f3;
    mem_addr_i = addr; mem_sdata_i = sdata; wd_i = wd; wreg_i = wreg; wdata_i = alu;
    @(posedge clk); #1;
    valid_i = 1'b0; mem_addr_i = $urandom; mem_sdata_i = $urandom; wd_i = 5'($urandom);
    wdata_i = $urandom; mem_func3_i = 3'($urandom); wreg_i = 1'($urandom);
    obs_lat = 1;
    obs_req = mem_req_o; obs_we = mem_we_o; obs_addr = mem_addr_o;
    obs_be = mem_be_o; obs_mwdata = mem_wdata_o;
    obs_stall_cnt = 0; obs_stable = 1'b1; obs_early_valid = 1'b0;
    if (mem_req_o === 1'b1) begin
      for (int i = 0; i < ack_wait; i++) begin
        if (stall_o === 1'b1) obs_stall_cnt++;
        mem_ack_i = 1'b0; mem_rdata_i = $urandom;
        @(posedge clk); #1;
        obs_lat++;
        if (valid_o !== 1'b0) obs_early_valid = 1'b1;
        if (mem_req_o !== 1'b1 || mem_we_o !== obs_we || mem_addr_o !== obs_addr ||
            mem_be_o !== obs_be || mem_wdata_o !== obs_mwdata) obs_stable = 1'b0;
      end
      if (stall_o === 1'b1) obs_stall_cnt++;
      mem_ack_i = 1'b1; mem_rdata_i = rdata;
      @(posedge clk); #1;
      obs_lat++;
      mem_ack_i = 1'b0; mem_rdata_i = $urandom;
    end
    obs_valid = valid_o; obs_wd = wd_o; obs_wreg = wreg_o; obs_wdata = wdata_o;
    obs_misalign = misalign_o; obs_stall_after = stall_o; obs_req_after = mem_req_o;
  endtask

  // Outputs while reset is held
  task automatic test_reset;
    rst = 1'b0; valid_i = 1'b0; mem_ack_i = 1'b0; mem_rd_i = 1'b0; mem_we_i = 1'b0;
    wd_i = '0; wreg_i = 1'b0; wdata_i = '0; mem_func3_i = '0; mem_addr_i = '0;
    mem_sdata_i = '0; mem_rdata_i = '0;
    #12;
    vectors++;
    if ({stall_o, mem_req_o, mem_we_o, valid_o, wreg_o, misalign_o} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl got %b need 000000",
               {stall_o, mem_req_o, mem_we_o, valid_o, wreg_o, misalign_o});
    end
    vectors++;
    if (wd_o !== 5'd0 || wdata_o !== 32'd0 || mem_addr_o !== 32'd0 ||
        mem_wdata_o !== 32'd0 || mem_be_o !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_data got wd=%h wdata=%h addr=%h mwdata=%h be=%b need all zero",
               wd_o, wdata_o, mem_addr_o, mem_wdata_o, mem_be_o);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // ALU passthrough, with a stray ack in IDLE that must be ignored
  task automatic test_alu;
    mem_ack_i = 1'b1;
    issue_op(0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd5, 1, 32'h0000_1234, 0);
    mem_ack_i = 1'b0;
    vectors++;
    if (obs_valid !== 1'b1 || obs_wd !== 5'd5 || obs_wreg !== 1'b1 ||
        obs_wdata !== 32'h1234 || obs_stall_after !== 1'b0 || obs_req !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL alu got v=%b wd=%0d wreg=%b wdata=%h stall=%b req=%b need 1 5 1 00001234 0 0",
               obs_valid, obs_wd, obs_wreg, obs_wdata, obs_stall_after, obs_req);
    end
    @(posedge clk); #1;
    vectors++;
    if (valid_o !== 1'b0 || wdata_o !== 32'h1234) begin
      miscompares++;
      $display("[TB] FAIL alu_pulse got v=%b wdata=%h need 0 00001234", valid_o, wdata_o);
    end
  endtask

  // Signed byte load from the top lane with three wait cycles
  task automatic test_lb;
    issue_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 5'd7, 1, 32'h0, 3);
    vectors++;
    if (obs_req !== 1'b1 || obs_we !== 1'b0 || obs_addr !== 32'h100 || obs_be !== 4'b1111) begin
      miscompares++;
      $display("[TB] FAIL lb_req got req=%b we=%b addr=%h be=%b need 1 0 00000100 1111",
               obs_req, obs_we, obs_addr, obs_be);
    end
    vectors++;
    if (obs_stall_cnt != 4 || obs_stable !== 1'b1 || obs_early_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL lb_busy got stall_cycles=%0d stable=%b early=%b need 4 1 0",
               obs_stall_cnt, obs_stable, obs_early_valid);
    end
    vectors++;
    if (obs_valid !== 1'b1 || obs_wdata !== 32'hFFFF_FF80 || obs_wd !== 5'd7 ||
        obs_wreg !== 1'b1 || obs_stall_after !== 1'b0 || obs_req_after !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL lb_wb got v=%b wdata=%h wd=%0d wreg=%b stall=%b req=%b need 1 ffffff80 7 1 0 0",
               obs_valid, obs_wdata, obs_wd, obs_wreg, obs_stall_after, obs_req_after);
    end
  endtask

  // Unsigned half load with immediate ack
  task automatic test_lhu;
    issue_op(1, 0, 3'b101, 32'h202, 32'h0, 32'hBEEF_0001, 5'd9, 1, 32'h0, 0);
    vectors++;
    if (obs_valid !== 1'b1 || obs_wdata !== 32'h0000_BEEF || obs_lat != 2 || obs_addr !== 32'h200) begin
      miscompares++;
      $display("[TB] FAIL lhu got v=%b wdata=%h lat=%0d addr=%h need 1 0000beef 2 00000200",
               obs_valid, obs_wdata, obs_lat, obs_addr);
    end
  endtask

  // Byte store into lane 1
  task automatic test_sb;
    issue_op(0, 1, 3'b000, 32'h301, 32'h1234_56AB, 32'h0, 5'd3, 1, 32'h0, 1);
    vectors++;
    if (obs_we !== 1'b1 || obs_be !== 4'b0010 || obs_mwdata !== 32'hABAB_ABAB || obs_addr !== 32'h300) begin
      miscompares++;
      $display("[TB] FAIL sb_req got we=%b be=%b mwdata=%h addr=%h need 1 0010 abababab 00000300",
               obs_we, obs_be, obs_mwdata, obs_addr);
    end
    vectors++;
    if (obs_valid !== 1'b1 || obs_wreg !== 1'b0 || obs_misalign !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sb_done got v=%b wreg=%b mis=%b need 1 0 0", obs_valid, obs_wreg, obs_misalign);
    end
  endtask

  // Misaligned word load never reaches memory
  task automatic test_misaligned;
    issue_op(1, 0, 3'b010, 32'h402, 32'h0, 32'h0, 5'd4, 1, 32'h0, 0);
    vectors++;
    if (obs_req !== 1'b0 || obs_valid !== 1'b1 || obs_misalign !== 1'b1 ||
        obs_wreg !== 1'b0 || obs_stall_after !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL misalign got req=%b v=%b mis=%b wreg=%b stall=%b need 0 1 1 0 0",
               obs_req, obs_valid, obs_misalign, obs_wreg, obs_stall_after);
    end
    @(posedge clk); #1;
    vectors++;
    if (misalign_o !== 1'b0 || valid_o !== 1'b0 || mem_req_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL misalign_pulse got mis=%b v=%b req=%b need 0 0 0", misalign_o, valid_o, mem_req_o);
    end
  endtask

  // Reset asserted while a load is outstanding
  task automatic test_reset_mid;
    logic seen_valid;
    valid_i = 1'b1; mem_rd_i = 1'b1; mem_we_i = 1'b0; mem_func3_i = 3'b010;
    mem_addr_i = 32'h500; wd_i = 5'd11; wreg_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (mem_req_o !== 1'b1 || stall_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_busy got req=%b stall=%b need 1 1", mem_req_o, stall_o);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_async got req=%b stall=%b need 0 0", mem_req_o, stall_o);
    end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1357_9BDF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (valid_o !== 1'b0 || mem_req_o !== 1'b0) seen_valid = 1'b1;
    end
    mem_ack_i = 1'b0;
    vectors++;
    if (seen_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_nowb got activity=%b need 0", seen_valid);
    end
    issue_op(0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd12, 1, 32'hCAFE_0001, 0);
    vectors++;
    if (obs_valid !== 1'b1 || obs_wdata !== 32'hCAFE_0001 || obs_wd !== 5'd12) begin
      miscompares++;
      $display("[TB] FAIL rstmid_alu got v=%b wdata=%h wd=%0d need 1 cafe0001 12", obs_valid, obs_wdata, obs_wd);
    end
  endtask

  // ALU ops on consecutive cycles retire one per cycle
  task automatic test_back_to_back;
    logic [31:0] vals [4];
    for (int i = 0; i < 4; i++) vals[i] = $urandom;
    mem_rd_i = 1'b0; mem_we_i = 1'b0; wreg_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; wd_i = 5'(i + 20); wdata_i = vals[i];
      @(posedge clk); #1;
      vectors++;
      if (valid_o !== 1'b1 || wdata_o !== vals[i] || wd_o !== 5'(i + 20) || stall_o !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL b2b_%0d got v=%b wdata=%h wd=%0d stall=%b need 1 %h %0d 0",
                 i, valid_o, wdata_o, wd_o, stall_o, vals[i], i + 20);
      end
    end
    valid_i = 1'b0;
  endtask

  // Random mix of ALU, load, store, illegal and misaligned operations
  task automatic test_random;
    exp_t e;
    bit rd, we, wreg;
    logic [2:0] f3;
    logic [31:0] addr, sdata, rdata, alu;
    logic [4:0] wd;
    int wt;
    for (int n = 0; n < 80; n++) begin
      rd = 1'($urandom); we = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin rd = 0; we = 0; end
      f3 = 3'($urandom); addr = $urandom; sdata = $urandom; rdata = $urandom;
      alu = $urandom; wd = 5'($urandom); wreg = 1'($urandom); wt = $urandom_range(0, 3);
      e = model(rd, we, f3, addr, sdata, rdata, wreg, alu, wt);
      issue_op(rd, we, f3, addr, sdata, rdata, wd, wreg, alu, wt);
      vectors++;
      if (obs_req !== e.req || obs_valid !== 1'b1 || obs_lat != e.lat ||
          obs_misalign !== e.misalign || obs_wreg !== e.wreg || obs_stall_after !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rand_ctrl_%0d got req=%b v=%b lat=%0d mis=%b wreg=%b stall=%b need %b 1 %0d %b %b 0",
                 n, obs_req, obs_valid, obs_lat, obs_misalign, obs_wreg, obs_stall_after,
                 e.req, e.lat, e.misalign, e.wreg);
      end
      if (e.req) begin
        vectors++;
        if (obs_we !== e.we || obs_addr !== e.addr || obs_be !== e.be ||
            (e.we && obs_mwdata !== e.mwdata) || obs_stable !== 1'b1 ||
            obs_stall_cnt != wt + 1) begin
          miscompares++;
          $display("[TB] FAIL rand_req_%0d got we=%b addr=%h be=%b mwdata=%h stable=%b stall=%0d need %b %h %b %h 1 %0d",
                   n, obs_we, obs_addr, obs_be, obs_mwdata, obs_stable, obs_stall_cnt,
                   e.we, e.addr, e.be, e.mwdata, wt + 1);
        end
      end
      if (e.chk_wdata) begin
        vectors++;
        if (obs_wdata !== e.wdata || (e.chk_wd && obs_wd !== wd)) begin
          miscompares++;
          $display("[TB] FAIL rand_wb_%0d got wdata=%h wd=%0d need %h %0d", n, obs_wdata, obs_wd, e.wdata, wd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_lhu();
    test_sb();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a stuck simulation
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout need completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
